// File: rtl/bbs32_seq_ctrl.sv
// bbs32_seq_ctrl: sequences bbs32 word generation into a FWFT output FIFO with M check and timeout
module bbs32_seq_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] cfg_p,
  input  logic [31:0] cfg_q,
  input  logic [31:0] cfg_seed,
  input  logic        cfg_load,
  input  logic        run,
  input  logic [15:0] num_words,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] eng_p,
  output logic [31:0] eng_q,
  output logic [31:0] eng_seed,
  output logic        eng_start,
  output logic        eng_keep_m,
  output logic        eng_use_xnext,
  input  logic [63:0] eng_m,
  input  logic        eng_m_valid,
  input  logic [31:0] eng_result,
  input  logic        eng_result_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, RELEASE} state_t;
  state_t state, state_nx;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [15:0] produced;
  logic [31:0] tcnt;
  logic seeded, load, launch, push, pop, tmo;
  assign load = cfg_load && state == IDLE;
  assign launch = state == IDLE && run && !cfg_load && cnt != FULL && (num_words == 16'd0 || produced < num_words);
  assign push = state == LAUNCH && eng_result_valid;
  assign tmo = state == LAUNCH && !eng_result_valid && tcnt == TO_LAST;
  assign pop = out_valid && out_ready;
  assign out_valid = cnt != '0;
  assign out_data = out_valid ? mem[rp] : '0;
  // next state and engine controls; seeded cannot change inside LAUNCH so controls stay constant
  always_comb begin
    state_nx = state == IDLE ? (launch ? LAUNCH : IDLE) :
               state == LAUNCH ? ((push || tmo) ? RELEASE : LAUNCH) : IDLE;
    busy = state != IDLE;
    eng_start = state == LAUNCH;
    eng_keep_m = eng_start && seeded;
    eng_use_xnext = eng_start && seeded;
  end
  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  // configuration, error flags, word accounting and the LAUNCH watchdog
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      {eng_p, eng_q, eng_seed} <= '0;
      seeded <= 1'b0;
      err <= 2'b00;
      produced <= '0;
      tcnt <= '0;
      done <= 1'b0;
    end else begin
      done <= push && num_words != 16'd0 && produced + 16'd1 == num_words;
      tcnt <= (state == LAUNCH && !eng_result_valid) ? tcnt + 32'd1 : '0;
      if (load) begin
        {eng_p, eng_q, eng_seed} <= {cfg_p, cfg_q, cfg_seed};
        seeded <= 1'b0;
        err <= 2'b00;
        produced <= '0;
      end else begin
        if (state == LAUNCH && !seeded && eng_m_valid && eng_m != 64'(eng_p) * 64'(eng_q)) err[0] <= 1'b1;
        if (tmo) begin
          err[1] <= 1'b1;
          seeded <= 1'b0;
        end
        if (push) begin
          seeded <= 1'b1;
          produced <= produced + {15'd0, produced != 16'hFFFF};
        end else if (state == IDLE && !run) produced <= '0;
      end
    end
  // FIFO pointers and occupancy; a load flushes the buffer
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (load) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  // FIFO storage; launch gating keeps pushes away from a full buffer
  always_ff @(posedge clk)
    if (push) mem[wp] <= eng_result;
endmodule

// File: tb/tb_bbs32_seq_ctrl.sv
// tb_bbs32_seq_ctrl: directed checks of bbs32_seq_ctrl against a behavioural engine
module tb_bbs32_seq_ctrl;
  localparam logic [31:0] P = 32'd29711, Q = 32'd45543, S = 32'd56686;
  logic clk = 1'b0, nrst = 1'b0;
  logic [31:0] cfg_p = '0, cfg_q = '0, cfg_seed = '0;
  logic cfg_load = 1'b0, run = 1'b0, out_ready = 1'b0;
  logic [15:0] num_words = '0;
  logic [31:0] out_data, eng_p, eng_q, eng_seed, eng_result;
  logic out_valid, busy, done, eng_start, eng_keep_m, eng_use_xnext, eng_m_valid, eng_result_valid;
  logic [1:0] err;
  logic [63:0] eng_m;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;

  bbs32_seq_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .nrst(nrst), .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_seed(cfg_seed),
    .cfg_load(cfg_load), .run(run), .num_words(num_words), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err),
    .eng_p(eng_p), .eng_q(eng_q), .eng_seed(eng_seed), .eng_start(eng_start),
    .eng_keep_m(eng_keep_m), .eng_use_xnext(eng_use_xnext), .eng_m(eng_m),
    .eng_m_valid(eng_m_valid), .eng_result(eng_result), .eng_result_valid(eng_result_valid)
  );

  function automatic logic [31:0] word(int k);
    return k == 0 ? 32'd1848907155 : (32'hC0DE_0000 ^ 32'(k * 7919));
  endfunction

  // engine: result after 4 LAUNCH cycles, word k from a fixed table, optional M error and mute
  int lat = 0, widx = 0;
  logic mute = 1'b0;
  logic [63:0] m_bias = '0;
  always @(posedge clk) begin
    lat <= eng_start ? lat + 1 : 0;
    if (eng_result_valid) widx <= widx + 1;
  end
  assign eng_result_valid = eng_start && lat == 3 && !mute;
  assign eng_result = word(widx);
  assign eng_m_valid = eng_start && !eng_keep_m;
  assign eng_m = {32'd0, eng_p} * {32'd0, eng_q} + m_bias;

  // observers: consumed words, done pulses, launch keep_m, RELEASE lengths
  logic [31:0] got[$];
  logic keeps[$];
  int done_cnt = 0, rel_bad = 0, keep_var = 0, rel_run = 0;
  logic prev_start = 1'b0, prev_keep = 1'b0;
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
    if (eng_start && !prev_start) keeps.push_back(eng_keep_m);
    if (eng_start && prev_start && eng_keep_m != prev_keep) keep_var++;
    if (busy && !eng_start) rel_run++;
    else begin
      if (rel_run > 1) rel_bad++;
      rel_run = 0;
    end
    prev_start = eng_start;
    prev_keep = eng_keep_m;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_cfg(input logic [15:0] nw, input logic r, input logic rdy);
    cfg_p = P; cfg_q = Q; cfg_seed = S;
    num_words = nw; run = r; out_ready = rdy; cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    seen = 0;
    tick(3);
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (eng_start || busy || done || out_valid) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL reset_idle: active cycles %0d want 0", seen); else n_pass++;
    n_chk++; if ({out_data, err} !== 34'd0) $display("FAIL reset_out: data %0h err %0b want 0", out_data, err); else n_pass++;
    n_chk++; if ({eng_p, eng_q, eng_seed} !== 96'd0) $display("FAIL reset_cfg: %0h %0h %0h want 0", eng_p, eng_q, eng_seed); else n_pass++;
    n_chk++; if ({eng_keep_m, eng_use_xnext} !== 2'b00) $display("FAIL reset_ctl: %0b want 00", {eng_keep_m, eng_use_xnext}); else n_pass++;
  endtask

  task automatic test_single;
    int g0, d0;
    g0 = got.size(); d0 = done_cnt;
    load_cfg(16'd1, 1'b1, 1'b1);
    n_chk++; if ({eng_p, eng_q, eng_seed} !== {P, Q, S}) $display("FAIL single_latch: %0d %0d %0d want %0d %0d %0d", eng_p, eng_q, eng_seed, P, Q, S); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_load_wins: busy %0b want 0", busy); else n_pass++;
    tick(1);
    n_chk++; if ({eng_start, eng_keep_m, eng_use_xnext} !== 3'b100) $display("FAIL single_launch: %0b want 100", {eng_start, eng_keep_m, eng_use_xnext}); else n_pass++;
    tick(20);
    n_chk++; if (err !== 2'b00) $display("FAIL single_err: %0b want 00", err); else n_pass++;
    n_chk++; if (got.size() - g0 != 1) $display("FAIL single_count: %0d want 1", got.size() - g0); else n_pass++;
    n_chk++; if (got.size() > g0 && got[g0] !== 32'd1848907155) $display("FAIL single_word: %0d want 1848907155", got[g0]); else n_pass++;
    n_chk++; if (done_cnt - d0 != 1) $display("FAIL single_done: %0d pulses want 1", done_cnt - d0); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_busy: %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int g0, k0, d0, r0, v0, base, bad;
    g0 = got.size(); k0 = keeps.size(); d0 = done_cnt; r0 = rel_bad; v0 = keep_var;
    load_cfg(16'd8, 1'b1, 1'b0);
    base = widx;
    tick(60);
    n_chk++; if ({busy, eng_start, out_valid} !== 3'b001) $display("FAIL b2b_full_state: %0b want 001", {busy, eng_start, out_valid}); else n_pass++;
    tick(10);
    n_chk++; if (keeps.size() - k0 != 4) $display("FAIL b2b_buffered: %0d launches want 4", keeps.size() - k0); else n_pass++;
    n_chk++; if (got.size() != g0) $display("FAIL b2b_no_pop: %0d want 0", got.size() - g0); else n_pass++;
    out_ready = 1'b1;
    tick(80);
    n_chk++; if (got.size() - g0 != 8) $display("FAIL b2b_total: %0d want 8", got.size() - g0); else n_pass++;
    bad = 0;
    for (int j = 0; j < 8 && g0 + j < got.size(); j++) if (got[g0 + j] !== word(base + j)) bad++;
    n_chk++; if (bad != 0) $display("FAIL b2b_order: %0d wrong words want 0", bad); else n_pass++;
    bad = 0;
    for (int j = 0; j < 8 && k0 + j < keeps.size(); j++) if (keeps[k0 + j] !== (j != 0)) bad++;
    n_chk++; if (bad != 0) $display("FAIL b2b_keep_m: %0d wrong launches want 0", bad); else n_pass++;
    n_chk++; if (rel_bad - r0 + keep_var - v0 != 0) $display("FAIL b2b_release: long releases %0d keep changes %0d want 0", rel_bad - r0, keep_var - v0); else n_pass++;
    n_chk++; if (done_cnt - d0 != 1) $display("FAIL b2b_done: %0d pulses want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_mismatch;
    int g0, base, bad;
    g0 = got.size();
    m_bias = 64'd1;
    load_cfg(16'd2, 1'b1, 1'b1);
    base = widx;
    tick(30);
    n_chk++; if (err !== 2'b01) $display("FAIL mism_err: %0b want 01", err); else n_pass++;
    bad = (got.size() - g0 != 2) ? 1 : 0;
    for (int j = 0; j < 2 && g0 + j < got.size(); j++) if (got[g0 + j] !== word(base + j)) bad++;
    n_chk++; if (bad != 0) $display("FAIL mism_words: %0d errors want 0", bad); else n_pass++;
    m_bias = '0;
    load_cfg(16'd2, 1'b0, 1'b1);
    n_chk++; if (err !== 2'b00) $display("FAIL mism_clear: %0b want 00", err); else n_pass++;
  endtask

  task automatic test_timeout;
    int g0, base, bad;
    g0 = got.size();
    load_cfg(16'd2, 1'b1, 1'b0);
    base = widx;
    tick(30);
    n_chk++; if ({out_valid, err} !== 3'b100) $display("FAIL tmo_setup: %0b want 100", {out_valid, err}); else n_pass++;
    mute = 1'b1;
    num_words = 16'd3;
    tick(1);
    n_chk++; if ({eng_start, eng_keep_m} !== 2'b11) $display("FAIL tmo_launch: %0b want 11", {eng_start, eng_keep_m}); else n_pass++;
    tick(15);
    n_chk++; if ({eng_start, err} !== 3'b100) $display("FAIL tmo_cycle16: %0b want 100", {eng_start, err}); else n_pass++;
    tick(1);
    n_chk++; if ({busy, eng_start, err} !== 4'b1010) $display("FAIL tmo_release: %0b want 1010", {busy, eng_start, err}); else n_pass++;
    tick(1);
    n_chk++; if (busy !== 1'b0) $display("FAIL tmo_idle: %0b want 0", busy); else n_pass++;
    tick(1);
    n_chk++; if ({eng_start, eng_keep_m, eng_use_xnext} !== 3'b100) $display("FAIL tmo_relaunch: %0b want 100", {eng_start, eng_keep_m, eng_use_xnext}); else n_pass++;
    mute = 1'b0;
    run = 1'b0;
    tick(15);
    out_ready = 1'b1;
    tick(20);
    bad = (got.size() - g0 != 3) ? 1 : 0;
    for (int j = 0; j < 3 && g0 + j < got.size(); j++) if (got[g0 + j] !== word(base + j)) bad++;
    n_chk++; if (bad != 0) $display("FAIL tmo_words: %0d errors (count %0d) want 0", bad, got.size() - g0); else n_pass++;
    n_chk++; if ({busy, err} !== 3'b010) $display("FAIL tmo_end: %0b want 010", {busy, err}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k0;
    k0 = keeps.size();
    load_cfg(16'd3, 1'b1, 1'b0);
    for (int i = 0; i < 40 && keeps.size() - k0 < 3; i++) tick(1);
    n_chk++; if ({keeps.size() - k0 == 3, eng_start, out_valid} !== 3'b111) $display("FAIL rmid_setup: launches %0d start %0b valid %0b want 3 1 1", keeps.size() - k0, eng_start, out_valid); else n_pass++;
    #2 nrst = 1'b0;
    #1;
    n_chk++; if ({eng_start, out_valid, busy, eng_keep_m} !== 4'b0000) $display("FAIL rmid_async: %0b want 0000", {eng_start, out_valid, busy, eng_keep_m}); else n_pass++;
    n_chk++; if (eng_p !== 32'd0) $display("FAIL rmid_cfg: %0d want 0", eng_p); else n_pass++;
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if ({eng_start, eng_keep_m, eng_use_xnext} !== 3'b100) $display("FAIL rmid_relaunch: %0b want 100", {eng_start, eng_keep_m, eng_use_xnext}); else n_pass++;
    run = 1'b0;
    tick(10);
    n_chk++; if ({busy, out_valid} !== 2'b01) $display("FAIL rmid_end: %0b want 01", {busy, out_valid}); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_mismatch;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bbs32_seq_ctrl.md
BBS32_SEQ_CTRL -- requirements
Module: bbs32_seq_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output word buffer depth (power of 2, >=2).
REQ-002 Parameter TIMEOUT_CYC, default 4096: max cycles in LAUNCH without eng_result_valid.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 nrst  in  1  asynchronous active-low reset.
REQ-006 cfg_p, cfg_q, cfg_seed  in  32 each  generator configuration (primes P, Q and seed).
REQ-007 cfg_load  in  1  single-cycle pulse; latch configuration.
REQ-008 run  in  1  level; enables word generation.
REQ-009 num_words  in  16  batch length; 0 = unlimited.
REQ-010 out_data  out  32  FIFO head word.
REQ-011 out_valid  out  1  FIFO not empty.
REQ-012 out_ready  in  1  consumer accepts out_data.
REQ-013 busy  out  1  FSM not in IDLE.
REQ-014 done  out  1  one-cycle pulse when batch completes.
REQ-015 err  out  2  sticky; bit0 = M mismatch, bit1 = engine timeout.
REQ-016 eng_p, eng_q, eng_seed  out  32 each  latched configuration to bbs32.
REQ-017 eng_start, eng_keep_m, eng_use_xnext  out  1 each  bbs32 controls.
REQ-018 eng_m  in  64; eng_m_valid  in  1; eng_result  in  32; eng_result_valid  in  1  bbs32 outputs.

Function
REQ-019 FSM states: IDLE, LAUNCH, RELEASE; busy = (state != IDLE).
REQ-020 IDLE -> LAUNCH when run=1, FIFO count < FIFO_DEPTH, and (num_words==0 or produced < num_words); no cfg_load that cycle.
REQ-021 LAUNCH: eng_start=1; eng_keep_m = eng_use_xnext = seeded flag; held constant for the whole LAUNCH.
REQ-022 First run after cfg_load (seeded=0): on first cycle eng_m_valid=1, compare eng_m with 64-bit product eng_p*eng_q; mismatch sets err[0]; generation continues.
REQ-023 LAUNCH, eng_result_valid=1: push eng_result into FIFO, produced+1, seeded<=1, go RELEASE.
REQ-024 RELEASE: eng_start=0, eng_keep_m=eng_use_xnext=0 for exactly one cycle, then IDLE.
REQ-025 Timeout: TIMEOUT_CYC consecutive LAUNCH cycles without eng_result_valid -> set err[1], seeded<=0, nothing pushed, go RELEASE.
REQ-026 done pulses the cycle after the push that makes produced == num_words (num_words != 0); never for num_words==0.
REQ-027 produced (16-bit) clears on cfg_load and whenever state==IDLE and run==0; saturates at 0xFFFF when num_words==0.
REQ-028 cfg_load honoured only in IDLE (ignored otherwise): latch cfg_* to eng_*, seeded<=0, err<=0, produced<=0, FIFO flushed.
REQ-029 cfg_load and launch conditions together in IDLE: load wins; launch earliest next cycle.
REQ-030 run falling during LAUNCH: current word completes and is pushed; then IDLE.
REQ-031 FIFO: FWFT; out_valid = count!=0; pop on out_valid&&out_ready; push+pop same cycle keeps count; launch gating guarantees no push when full.
REQ-032 Word order preserved; no word dropped or duplicated.

Reset
REQ-033 nrst=0 asynchronously forces: state IDLE, eng_start/eng_keep_m/eng_use_xnext=0, eng_p/q/seed=0, FIFO empty, out_valid=0, out_data=0, busy=0, done=0, err=0, produced=0, seeded=0, timeout counter=0.
REQ-034 Reset during LAUNCH drops eng_start immediately; post-reset first launch uses keep_m=use_xnext=0.

Verification
REQ-035 Reset release, no stimulus -> all outputs 0, eng_start never asserted.
REQ-036 cfg_load P=29711 Q=45543 seed=56686, num_words=1, run=1, out_ready=1, real bbs32 attached -> eng_keep_m=0, eng_m=1353128073, err=0, out_data=1848907155, done one pulse, busy returns 0.
REQ-037 Same config, num_words=8, out_ready=0 -> exactly 4 words buffered, eng_start stays 0; out_ready=1 -> 8 words total in order, words 2-8 launched with keep_m=use_xnext=1, RELEASE 1 cycle each.
REQ-038 Engine model returns eng_m = P*Q+1 -> err=2'b01, words still delivered; cfg_load in IDLE -> err=0.
REQ-039 TIMEOUT_CYC=16, engine never asserts eng_result_valid -> err[1]=1 after 16 LAUNCH cycles, eng_start low 1 cycle, next launch keep_m=0, FIFO count unchanged.
REQ-040 nrst pulse mid-LAUNCH with 2 words buffered -> eng_start 0 same cycle, out_valid=0, next launch keep_m=0.
